// File: rtl/writeback_unit.sv
// Write-back stage: captures retiring results into a small pending-write FIFO,
// drains one register-bank write per cycle and forwards pending values to decode.
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_regwrite,
  input  logic [1:0]                 in_sel,
  input  logic [REG_AW-1:0]          in_rd,
  input  logic [DATA_W-1:0]          in_alu,
  input  logic [DATA_W-1:0]          in_mem,
  input  logic [DATA_W-1:0]          in_pc4,
  input  logic                       rf_busy,
  output logic                       write_reg_flag,
  output logic [REG_AW-1:0]          write_reg,
  output logic [DATA_W-1:0]          write_data,
  input  logic [REG_AW-1:0]          fwd_rs,
  input  logic [REG_AW-1:0]          fwd_rt,
  output logic                       fwd_a_hit,
  output logic [DATA_W-1:0]          fwd_a_data,
  output logic                       fwd_b_hit,
  output logic [DATA_W-1:0]          fwd_b_data,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] fifo_rd_reg   [DEPTH];
  logic [DATA_W-1:0] fifo_data_reg [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [DEPTH-1:0]  entry_valid;
  logic [DATA_W-1:0] sel_data;
  logic              push, pop;

  assign in_ready = (count_reg < CW'(DEPTH));
  assign pending  = count_reg;

  always_comb begin
    sel_data = in_alu;
    case (in_sel)
      2'b01:   sel_data = in_mem;
      2'b10:   sel_data = in_pc4;
      default: sel_data = in_alu;
    endcase
  end

  // Writes to r0 or non-writing instructions are accepted but never queued.
  assign push = in_valid & in_ready & in_regwrite & (in_rd != '0);
  assign pop  = (count_reg != '0) & ~rf_busy;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_reg[wr_ptr_reg]   <= in_rd;
      fifo_data_reg[wr_ptr_reg] <= sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      write_reg_flag <= 1'b0;
      write_reg      <= '0;
      write_data     <= '0;
    end else begin
      count_reg      <= count_next;
      write_reg_flag <= pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        write_reg  <= fifo_rd_reg[rd_ptr_reg];
        write_data <= fifo_data_reg[rd_ptr_reg];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PW-1:0] age;
      assign age             = PW'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, age} < count_reg);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overrides; output register is oldest.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    if (write_reg_flag && write_reg == fwd_rs) begin
      fwd_a_hit  = 1'b1;
      fwd_a_data = write_data;
    end
    if (write_reg_flag && write_reg == fwd_rt) begin
      fwd_b_hit  = 1'b1;
      fwd_b_data = write_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PW'(k);
      if (entry_valid[idx] && fifo_rd_reg[idx] == fwd_rs) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = fifo_data_reg[idx];
      end
      if (entry_valid[idx] && fifo_rd_reg[idx] == fwd_rt) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = fifo_data_reg[idx];
      end
    end
    if (fwd_rs == '0) begin
      fwd_a_hit  = 1'b0;
      fwd_a_data = '0;
    end
    if (fwd_rt == '0) begin
      fwd_b_hit  = 1'b0;
      fwd_b_data = '0;
    end
  end

endmodule
